// File: rtl/ddr5_cmd_responder.sv
// Device-side DDR5 rank model: per-bank state, timing-rule checks on each command,
// accept/reject pulses with a reason code, and read completions tCL cycles after RD.
module ddr5_cmd_responder #(
  parameter int NUM_BG       = 2,
  parameter int BANKS_PER_BG = 2,
  parameter int TAG_W        = 4,
  parameter int CNT_W        = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  input  logic [2:0]                       cmd,
  input  logic [$clog2(NUM_BG)-1:0]        cmd_bg,
  input  logic [$clog2(BANKS_PER_BG)-1:0]  cmd_ba,
  input  logic [15:0]                      cmd_row,
  input  logic [TAG_W-1:0]                 cmd_tag,
  output logic                             acc_valid,
  output logic                             err_valid,
  output logic [3:0]                       err_code,
  output logic                             rd_valid,
  output logic [TAG_W-1:0]                 rd_tag,
  output logic [NUM_BG*BANKS_PER_BG-1:0]   bank_open
);

  localparam int NB  = NUM_BG * BANKS_PER_BG;
  localparam int BGW = $clog2(NUM_BG);
  localparam int BAW = $clog2(BANKS_PER_BG);

  localparam int T_RC = 226, T_RAS = 152, T_RRD_L = 22, T_RRD_S = 14, T_RP = 74;
  localparam int T_RFC = 710, T_CL = 80, T_RCD = 76, T_CCD_L = 22, T_CCD_S = 14;

  localparam logic [2:0] OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4, OP_REF = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NB-1:0]          open_q, open_d;
  logic [15:0]            row_q [NB];
  logic [15:0]            row_d [NB];
  logic [CNT_W-1:0]       since_act_q [NB];
  logic [CNT_W-1:0]       since_act_d [NB];
  logic [CNT_W-1:0]       since_pre_q [NB];
  logic [CNT_W-1:0]       since_pre_d [NB];
  logic [CNT_W-1:0]       since_rd_q  [NB];
  logic [CNT_W-1:0]       since_rd_d  [NB];
  logic [CNT_W-1:0]       since_act_any_q, since_act_any_d;
  logic [CNT_W-1:0]       since_cas_any_q, since_cas_any_d;
  logic [BGW-1:0]         last_act_bg_q, last_act_bg_d;
  logic [BGW-1:0]         last_cas_bg_q, last_cas_bg_d;
  logic [CNT_W-1:0]       ref_q, ref_d;
  logic                   acc_q, err_q;
  logic [3:0]             code_q;
  logic [TAG_W:0]         pipe_q [T_CL];

  logic [BGW+BAW-1:0]     idx;
  logic                   is_cmd, accept, rd_push, pre_recent;
  logic [3:0]             code;

  assign idx = {cmd_bg, cmd_ba};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    pre_recent = 1'b0;
    for (int unsigned i = 0; i < NB; i++)
      if (since_pre_q[i] < CNT_W'(T_RP)) pre_recent = 1'b1;

    is_cmd = cmd_valid && (cmd != OP_NOP);
    code   = 4'd0;
    if (ref_q != '0) begin
      code = 4'd1;
    end else begin
      case (cmd)
        OP_NOP: code = 4'd0;
        OP_ACT: begin
          if (open_q[idx])                                code = 4'd2;
          else if (since_pre_q[idx] < CNT_W'(T_RP))       code = 4'd3;
          else if (since_act_q[idx] < CNT_W'(T_RC))       code = 4'd4;
          else if (since_act_any_q < ((cmd_bg == last_act_bg_q) ?
                   CNT_W'(T_RRD_L) : CNT_W'(T_RRD_S)))    code = 4'd5;
        end
        OP_RD, OP_WR: begin
          if (!open_q[idx])                               code = 4'd6;
          else if (since_act_q[idx] < CNT_W'(T_RCD))      code = 4'd7;
          else if (since_cas_any_q < ((cmd_bg == last_cas_bg_q) ?
                   CNT_W'(T_CCD_L) : CNT_W'(T_CCD_S)))    code = 4'd8;
        end
        OP_PRE: if (open_q[idx] && (since_act_q[idx] < CNT_W'(T_RAS))) code = 4'd9;
        OP_REF: if ((|open_q) || pre_recent)              code = 4'd10;
        default:                                          code = 4'd11;
      endcase
    end
    accept = is_cmd && (code == 4'd0);
  end

  // Counters restart at 1, not 0: a command N cycles after the event must observe N.
  always_comb begin
    open_d          = open_q;
    since_act_any_d = sat_inc(since_act_any_q);
    since_cas_any_d = sat_inc(since_cas_any_q);
    last_act_bg_d   = last_act_bg_q;
    last_cas_bg_d   = last_cas_bg_q;
    ref_d           = (ref_q != '0) ? ref_q - CNT_ONE : '0;
    rd_push         = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      row_d[i]       = row_q[i];
      since_act_d[i] = sat_inc(since_act_q[i]);
      since_pre_d[i] = sat_inc(since_pre_q[i]);
      since_rd_d[i]  = sat_inc(since_rd_q[i]);
    end
    if (accept) begin
      case (cmd)
        OP_ACT: begin
          open_d[idx]      = 1'b1;
          row_d[idx]       = cmd_row;
          since_act_d[idx] = CNT_ONE;
          since_act_any_d  = CNT_ONE;
          last_act_bg_d    = cmd_bg;
        end
        OP_RD, OP_WR: begin
          since_cas_any_d = CNT_ONE;
          last_cas_bg_d   = cmd_bg;
          if (cmd == OP_RD) begin
            since_rd_d[idx] = CNT_ONE;
            rd_push         = 1'b1;
          end
        end
        OP_PRE: if (open_q[idx]) begin
          open_d[idx]      = 1'b0;
          since_pre_d[idx] = CNT_ONE;
        end
        // Loaded one short so the command exactly tRFC cycles later is the first accepted.
        OP_REF: ref_d = CNT_W'(T_RFC - 1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q          <= '0;
      since_act_any_q <= '1;
      since_cas_any_q <= '1;
      last_act_bg_q   <= '0;
      last_cas_bg_q   <= '0;
      ref_q           <= '0;
      acc_q           <= 1'b0;
      err_q           <= 1'b0;
      code_q          <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        row_q[i]       <= '0;
        since_act_q[i] <= '1;
        since_pre_q[i] <= '1;
        since_rd_q[i]  <= '1;
      end
      for (int unsigned i = 0; i < T_CL; i++) pipe_q[i] <= '0;
    end else begin
      open_q          <= open_d;
      since_act_any_q <= since_act_any_d;
      since_cas_any_q <= since_cas_any_d;
      last_act_bg_q   <= last_act_bg_d;
      last_cas_bg_q   <= last_cas_bg_d;
      ref_q           <= ref_d;
      acc_q           <= accept;
      err_q           <= is_cmd && (code != 4'd0);
      code_q          <= is_cmd ? code : 4'd0;
      for (int unsigned i = 0; i < NB; i++) begin
        row_q[i]       <= row_d[i];
        since_act_q[i] <= since_act_d[i];
        since_pre_q[i] <= since_pre_d[i];
        since_rd_q[i]  <= since_rd_d[i];
      end
      pipe_q[0] <= rd_push ? {1'b1, cmd_tag} : '0;
      for (int unsigned i = 1; i < T_CL; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign acc_valid = acc_q;
  assign err_valid = err_q;
  assign err_code  = code_q;
  assign rd_valid  = pipe_q[T_CL-1][TAG_W];
  assign rd_tag    = pipe_q[T_CL-1][TAG_W-1:0];
  assign bank_open = open_q;

endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// Directed bench for ddr5_cmd_responder: timing-rule boundaries, read latency,
// refresh lockout and reset with reads in flight.
module tb_ddr5_cmd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [0:0]  cmd_bg, cmd_ba;
  logic [15:0] cmd_row;
  logic [3:0]  cmd_tag;
  logic        acc_valid, err_valid, rd_valid;
  logic [3:0]  err_code, rd_tag, bank_open;

  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;
  int unsigned cyc = 0;

  ddr5_cmd_responder #(.NUM_BG(2), .BANKS_PER_BG(2), .TAG_W(4), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg),
    .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_tag(cmd_tag), .acc_valid(acc_valid),
    .err_valid(err_valid), .err_code(err_code), .rd_valid(rd_valid), .rd_tag(rd_tag),
    .bank_open(bank_open)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step();
  endtask

  // Presents a command during cycle `cyc`; on return its result pulse is visible.
  task automatic send(input logic [2:0] op, input logic bg, input logic ba,
                      input logic [3:0] tag);
    cmd_valid = 1'b1; cmd = op; cmd_bg = bg; cmd_ba = ba;
    cmd_row = 16'hA000 + 16'(cyc); cmd_tag = tag;
    step();
    cmd_valid = 1'b0; cmd = 3'd0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; cmd = 3'd0; cmd_bg = 1'b0; cmd_ba = 1'b0; cmd_row = '0; cmd_tag = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; cyc = 0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0; cmd = 3'd0; cmd_bg = 1'b0; cmd_ba = 1'b0; cmd_row = '0; cmd_tag = '0;
    rst = 1'b1; #2;
    chk_cnt++;
    if ({acc_valid, err_valid, err_code, rd_valid, rd_tag, bank_open} !== 15'd0)
      $display("FAIL reset_outputs acc=%b err=%b code=%0d rd=%b tag=%0d open=%b expected all 0",
               acc_valid, err_valid, err_code, rd_valid, rd_tag, bank_open);
    else pass_cnt++;
    do_reset();
    send(3'd1, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1 || err_valid !== 1'b0)
      $display("FAIL reset_first_act acc=%b err=%b code=%0d expected acc=1", acc_valid, err_valid, err_code);
    else pass_cnt++;
  endtask

  task automatic test_act_rd();
    do_reset();
    send(3'd1, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1 || bank_open !== 4'b0001)
      $display("FAIL act_rd_act acc=%b open=%b expected acc=1 open=0001", acc_valid, bank_open);
    else pass_cnt++;
    wait_until(76);
    send(3'd2, 1'b0, 1'b0, 4'd5);
    chk_cnt++;
    if (acc_valid !== 1'b1 || err_valid !== 1'b0)
      $display("FAIL act_rd_rd acc=%b err=%b code=%0d expected acc=1", acc_valid, err_valid, err_code);
    else pass_cnt++;
    wait_until(155);
    chk_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL rd_early rd_valid=%b expected 0 at cycle 155", rd_valid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (rd_valid !== 1'b1 || rd_tag !== 4'd5)
      $display("FAIL rd_latency rd_valid=%b tag=%0d expected 1/5 at cycle 156", rd_valid, rd_tag);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL rd_single_pulse rd_valid=%b expected 0 at cycle 157", rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_rcd_ccd();
    do_reset();
    send(3'd1, 1'b0, 1'b0, 4'd0);
    send(3'd2, 1'b0, 1'b1, 4'd1);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd6 || acc_valid !== 1'b0)
      $display("FAIL rd_closed err=%b code=%0d expected err=1 code=6", err_valid, err_code);
    else pass_cnt++;
    wait_until(75);
    send(3'd2, 1'b0, 1'b0, 4'd2);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd7)
      $display("FAIL rcd_early err=%b code=%0d expected err=1 code=7", err_valid, err_code);
    else pass_cnt++;
    send(3'd2, 1'b0, 1'b0, 4'd2);
    chk_cnt++;
    if (acc_valid !== 1'b1 || err_code !== 4'd0)
      $display("FAIL rcd_met acc=%b code=%0d expected acc=1 code=0", acc_valid, err_code);
    else pass_cnt++;
    wait_until(97);
    send(3'd3, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd8)
      $display("FAIL ccd_l_early err=%b code=%0d expected err=1 code=8", err_valid, err_code);
    else pass_cnt++;
    send(3'd3, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1)
      $display("FAIL ccd_l_met acc=%b code=%0d expected acc=1", acc_valid, err_code);
    else pass_cnt++;
  endtask

  task automatic test_ras_rp();
    do_reset();
    send(3'd1, 1'b0, 1'b0, 4'd0);
    wait_until(151);
    send(3'd4, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd9)
      $display("FAIL ras_early err=%b code=%0d expected err=1 code=9", err_valid, err_code);
    else pass_cnt++;
    send(3'd4, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1 || bank_open !== 4'b0000)
      $display("FAIL ras_met acc=%b open=%b expected acc=1 open=0000", acc_valid, bank_open);
    else pass_cnt++;
    send(3'd4, 1'b0, 1'b1, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1) $display("FAIL pre_closed acc=%b code=%0d expected acc=1", acc_valid, err_code);
    else pass_cnt++;
    send(3'd1, 1'b0, 1'b1, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1 || bank_open !== 4'b0010)
      $display("FAIL pre_closed_noop acc=%b code=%0d open=%b expected acc=1 open=0010",
               acc_valid, err_code, bank_open);
    else pass_cnt++;
    wait_until(225);
    send(3'd1, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd3)
      $display("FAIL rp_early err=%b code=%0d expected err=1 code=3", err_valid, err_code);
    else pass_cnt++;
    send(3'd1, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1 || bank_open !== 4'b0011)
      $display("FAIL rc_rp_met acc=%b open=%b expected acc=1 open=0011", acc_valid, bank_open);
    else pass_cnt++;
    send(3'd1, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd2)
      $display("FAIL act_open err=%b code=%0d expected err=1 code=2", err_valid, err_code);
    else pass_cnt++;
  endtask

  task automatic test_rrd();
    do_reset();
    send(3'd1, 1'b0, 1'b0, 4'd0);
    wait_until(13);
    send(3'd1, 1'b1, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd5)
      $display("FAIL rrd_s_early err=%b code=%0d expected err=1 code=5", err_valid, err_code);
    else pass_cnt++;
    send(3'd1, 1'b1, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1) $display("FAIL rrd_s_met acc=%b code=%0d expected acc=1", acc_valid, err_code);
    else pass_cnt++;
    wait_until(35);
    send(3'd1, 1'b1, 1'b1, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd5)
      $display("FAIL rrd_l_early err=%b code=%0d expected err=1 code=5", err_valid, err_code);
    else pass_cnt++;
    send(3'd1, 1'b1, 1'b1, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1 || bank_open !== 4'b1101)
      $display("FAIL rrd_l_met acc=%b open=%b expected acc=1 open=1101", acc_valid, bank_open);
    else pass_cnt++;
  endtask

  task automatic test_refresh();
    do_reset();
    send(3'd1, 1'b0, 1'b0, 4'd0);
    send(3'd5, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd10)
      $display("FAIL ref_open err=%b code=%0d expected err=1 code=10", err_valid, err_code);
    else pass_cnt++;
    wait_until(152);
    send(3'd4, 1'b0, 1'b0, 4'd0);
    wait_until(225);
    send(3'd5, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd10)
      $display("FAIL ref_rp_early err=%b code=%0d expected err=1 code=10", err_valid, err_code);
    else pass_cnt++;
    send(3'd5, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1) $display("FAIL ref_accept acc=%b code=%0d expected acc=1", acc_valid, err_code);
    else pass_cnt++;
    wait_until(934);
    send(3'd7, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd1)
      $display("FAIL ref_busy_illegal err=%b code=%0d expected err=1 code=1", err_valid, err_code);
    else pass_cnt++;
    send(3'd1, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd1)
      $display("FAIL ref_busy_act err=%b code=%0d expected err=1 code=1", err_valid, err_code);
    else pass_cnt++;
    send(3'd1, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b1 || bank_open !== 4'b0001)
      $display("FAIL ref_done_act acc=%b open=%b expected acc=1 open=0001", acc_valid, bank_open);
    else pass_cnt++;
    send(3'd6, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (err_valid !== 1'b1 || err_code !== 4'd11)
      $display("FAIL illegal_op err=%b code=%0d expected err=1 code=11", err_valid, err_code);
    else pass_cnt++;
    send(3'd0, 1'b0, 1'b0, 4'd0);
    chk_cnt++;
    if (acc_valid !== 1'b0 || err_valid !== 1'b0 || err_code !== 4'd0)
      $display("FAIL nop_silent acc=%b err=%b code=%0d expected 0/0/0", acc_valid, err_valid, err_code);
    else pass_cnt++;
  endtask

  task automatic setup_two_reads();
    do_reset();
    send(3'd1, 1'b0, 1'b0, 4'd0);
    wait_until(14);
    send(3'd1, 1'b1, 1'b0, 4'd0);
    wait_until(90);
    send(3'd2, 1'b0, 1'b0, 4'd3);
    wait_until(104);
    send(3'd2, 1'b1, 1'b0, 4'd9);
    chk_cnt++;
    if (acc_valid !== 1'b1)
      $display("FAIL ccd_s_met acc=%b code=%0d expected acc=1", acc_valid, err_code);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    setup_two_reads();
    wait_until(169);
    chk_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL b2b_pre rd_valid=%b expected 0 at 169", rd_valid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (rd_valid !== 1'b1 || rd_tag !== 4'd3)
      $display("FAIL b2b_first rd_valid=%b tag=%0d expected 1/3 at 170", rd_valid, rd_tag);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL b2b_gap rd_valid=%b expected 0 at 171", rd_valid);
    else pass_cnt++;
    wait_until(184);
    chk_cnt++;
    if (rd_valid !== 1'b1 || rd_tag !== 4'd9)
      $display("FAIL b2b_second rd_valid=%b tag=%0d expected 1/9 at 184", rd_valid, rd_tag);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL b2b_post rd_valid=%b expected 0 at 185", rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    logic seen;
    setup_two_reads();
    wait_until(144);
    rst = 1'b1; #1;
    chk_cnt++;
    if ({acc_valid, err_valid, err_code, rd_valid, rd_tag, bank_open} !== 15'd0)
      $display("FAIL midreset_outputs acc=%b err=%b code=%0d rd=%b tag=%0d open=%b expected all 0",
               acc_valid, err_valid, err_code, rd_valid, rd_tag, bank_open);
    else pass_cnt++;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen |= rd_valid; end
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      seen |= rd_valid;
    end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL midreset_no_rd rd_valid seen=%b expected 0", seen);
    else pass_cnt++;
    chk_cnt++;
    if (bank_open !== 4'b0000) $display("FAIL midreset_banks open=%b expected 0000", bank_open);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_act_rd();
    test_rcd_ccd();
    test_ras_rp();
    test_rrd();
    test_refresh();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
